// File: rtl/tlight_pkg.sv
// Shared types for the traffic-light controller: phase encoding and the
// per-way lamp triple with its decode helper.
package tlight_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED   = 3'd0,
        PH_RED_AMBER = 3'd1,
        PH_GREEN     = 3'd2,
        PH_AMBER     = 3'd3,
        PH_WALK      = 3'd4,
        PH_FLASH     = 3'd5
    } phase_t;

    typedef struct packed {
        logic r;
        logic a;
        logic g;
    } rag_t;

    // Lamp triple for one way; inactive ways sit on red except in FLASH,
    // where every way shows the shared flashing amber.
    function automatic rag_t way_lamp(phase_t ph, logic active, logic flash_on);
        rag_t l;
        l = '{r: 1'b1, a: 1'b0, g: 1'b0};
        case (ph)
            PH_RED_AMBER: l.a = active;
            PH_GREEN: begin
                l.r = ~active;
                l.g = active;
            end
            PH_AMBER: begin
                l.r = ~active;
                l.a = active;
            end
            PH_FLASH: begin
                l.r = 1'b0;
                l.a = flash_on;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each controller phase; done marks the last
// cycle of the loaded length.
module phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/tlight_ctrl.sv
// Multi-way traffic-light controller with pedestrian walk phase and
// flashing-amber fault mode; lamps are registered from the next state.
module tlight_ctrl
    import tlight_pkg::*;
#(
    parameter int N_WAYS  = 2,
    parameter int CNT_W   = 8,
    parameter int T_RA    = 2,
    parameter int T_G     = 4,
    parameter int T_A     = 3,
    parameter int T_AR    = 1,
    parameter int T_WALK  = 5,
    parameter int T_FLASH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flash,
    input  logic              ped_req,
    output logic [N_WAYS-1:0] r,
    output logic [N_WAYS-1:0] a,
    output logic [N_WAYS-1:0] g,
    output logic              walk,
    output logic              ped_wait,
    output logic [2:0]        phase_dbg,
    output logic [1:0]        way_dbg
);

    phase_t     phase, nxt_phase;
    logic [1:0] w, nxt_w;
    logic       pend, nxt_pend;
    logic       wrapped, nxt_wrapped;
    logic       flash_on, nxt_flash_on;
    logic       load;
    logic [CNT_W-1:0] load_val;
    logic       done;

    logic [N_WAYS-1:0] r_nxt, a_nxt, g_nxt;
    rag_t       rag_tmp;

    phase_timer #(.CNT_W(CNT_W), .RST_VAL(T_AR)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // wrapped marks an ALL_RED reached by finishing the last way, the only
    // ALL_RED from which a pending walk may be served.
    always_comb begin
        nxt_phase    = phase;
        nxt_w        = w;
        nxt_pend     = pend | ped_req;
        nxt_wrapped  = wrapped;
        nxt_flash_on = flash_on;
        load         = 1'b0;
        load_val     = CNT_W'(T_AR);
        if (flash) begin
            if (phase != PH_FLASH) begin
                nxt_phase    = PH_FLASH;
                nxt_flash_on = 1'b1;
                load         = 1'b1;
                load_val     = CNT_W'(T_FLASH);
            end else if (done) begin
                nxt_flash_on = ~flash_on;
                load         = 1'b1;
                load_val     = CNT_W'(T_FLASH);
            end
        end else if (phase == PH_FLASH) begin
            nxt_phase   = PH_ALL_RED;
            nxt_w       = 2'd0;
            nxt_wrapped = 1'b0;
            load        = 1'b1;
            load_val    = CNT_W'(T_AR);
        end else if (done) begin
            load = 1'b1;
            case (phase)
                PH_ALL_RED: begin
                    nxt_wrapped = 1'b0;
                    if (wrapped && pend) begin
                        nxt_phase = PH_WALK;
                        nxt_pend  = ped_req;
                        load_val  = CNT_W'(T_WALK);
                    end else begin
                        nxt_phase = PH_RED_AMBER;
                        load_val  = CNT_W'(T_RA);
                    end
                end
                PH_RED_AMBER: begin
                    nxt_phase = PH_GREEN;
                    load_val  = CNT_W'(T_G);
                end
                PH_GREEN: begin
                    nxt_phase = PH_AMBER;
                    load_val  = CNT_W'(T_A);
                end
                PH_AMBER: begin
                    nxt_phase = PH_ALL_RED;
                    load_val  = CNT_W'(T_AR);
                    if (w == 2'(N_WAYS - 1)) begin
                        nxt_w       = 2'd0;
                        nxt_wrapped = 1'b1;
                    end else begin
                        nxt_w = w + 2'd1;
                    end
                end
                PH_WALK: begin
                    nxt_phase = PH_ALL_RED;
                    nxt_w     = 2'd0;
                    load_val  = CNT_W'(T_AR);
                end
                default: begin
                    nxt_phase = PH_ALL_RED;
                    nxt_w     = 2'd0;
                    load_val  = CNT_W'(T_AR);
                end
            endcase
        end
    end

    always_comb begin
        r_nxt   = '0;
        a_nxt   = '0;
        g_nxt   = '0;
        rag_tmp = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            rag_tmp  = way_lamp(nxt_phase, nxt_w == 2'(i), nxt_flash_on);
            r_nxt[i] = rag_tmp.r;
            a_nxt[i] = rag_tmp.a;
            g_nxt[i] = rag_tmp.g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_ALL_RED;
            w        <= 2'd0;
            pend     <= 1'b0;
            wrapped  <= 1'b0;
            flash_on <= 1'b0;
            r        <= '1;
            a        <= '0;
            g        <= '0;
            walk     <= 1'b0;
            ped_wait <= 1'b0;
        end else begin
            phase    <= nxt_phase;
            w        <= nxt_w;
            pend     <= nxt_pend;
            wrapped  <= nxt_wrapped;
            flash_on <= nxt_flash_on;
            r        <= r_nxt;
            a        <= a_nxt;
            g        <= g_nxt;
            walk     <= (nxt_phase == PH_WALK);
            ped_wait <= nxt_pend;
        end
    end

    assign phase_dbg = phase;
    assign way_dbg   = w;

endmodule

// File: tb/tb_tlight_ctrl.sv
// Directed bench for tlight_ctrl: a 2-way default instance driven from a
// vector table, plus a 4-way short-timer instance and an async reset case.
module tb_tlight_ctrl;

    logic clk;
    logic rst_n, flash, ped_req;
    logic [1:0] r, a, g;
    logic walk, ped_wait;
    logic [2:0] phase_dbg;
    logic [1:0] way_dbg;

    logic rst_n4, flash4, ped_req4;
    logic [3:0] r4, a4, g4;
    logic walk4, ped_wait4;
    logic [2:0] phase_dbg4;
    logic [1:0] way_dbg4;

    int n_vec = 0;
    int n_err = 0;

    tlight_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flash(flash), .ped_req(ped_req),
        .r(r), .a(a), .g(g), .walk(walk), .ped_wait(ped_wait),
        .phase_dbg(phase_dbg), .way_dbg(way_dbg)
    );

    tlight_ctrl #(.N_WAYS(4), .CNT_W(2), .T_G(1), .T_WALK(3)) dut4 (
        .clk(clk), .rst_n(rst_n4), .flash(flash4), .ped_req(ped_req4),
        .r(r4), .a(a4), .g(g4), .walk(walk4), .ped_wait(ped_wait4),
        .phase_dbg(phase_dbg4), .way_dbg(way_dbg4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flash;
        logic       ped;
        int         n;
        logic [1:0] r;
        logic [1:0] a;
        logic [1:0] g;
        logic       walk;
        logic       pw;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic f, input logic p, input int n,
                       input logic [1:0] er, input logic [1:0] ea,
                       input logic [1:0] eg, input logic ew, input logic epw);
        vec_t v;
        v.flash = f; v.ped = p; v.n = n;
        v.r = er; v.a = ea; v.g = eg; v.walk = ew; v.pw = epw;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 2-way lamp shorthands, bit order {way1, way0}
    task automatic add_ra0(input logic f, input logic p, input int n, input logic pw);
        add(f, p, n, 2'b11, 2'b01, 2'b00, 1'b0, pw);
    endtask
    task automatic add_g0(input logic p, input int n, input logic pw);
        add(1'b0, p, n, 2'b10, 2'b00, 2'b01, 1'b0, pw);
    endtask
    task automatic add_a0(input int n, input logic pw);
        add(1'b0, 1'b0, n, 2'b10, 2'b01, 2'b00, 1'b0, pw);
    endtask
    task automatic add_ar(input logic f, input logic p, input int n, input logic pw);
        add(f, p, n, 2'b11, 2'b00, 2'b00, 1'b0, pw);
    endtask
    task automatic add_ra1(input int n, input logic pw);
        add(1'b0, 1'b0, n, 2'b11, 2'b10, 2'b00, 1'b0, pw);
    endtask
    task automatic add_g1(input int n, input logic pw);
        add(1'b0, 1'b0, n, 2'b01, 2'b00, 2'b10, 1'b0, pw);
    endtask
    task automatic add_a1(input int n, input logic pw);
        add(1'b0, 1'b0, n, 2'b01, 2'b10, 2'b00, 1'b0, pw);
    endtask
    task automatic add_walk(input logic p, input int n, input logic pw);
        add(1'b0, p, n, 2'b11, 2'b00, 2'b00, 1'b1, pw);
    endtask

    // one cycle on the 2-way DUT: drive, clock, then compare #1 after the edge
    task automatic cycle2(input string name, input logic f, input logic p,
                          input logic [1:0] er, input logic [1:0] ea,
                          input logic [1:0] eg, input logic ew, input logic epw);
        flash = f;
        ped_req = p;
        @(posedge clk);
        #1;
        chk(name, {24'd0, r, a, g, walk, ped_wait}, {24'd0, er, ea, eg, ew, epw});
        chk({name, "_g_onehot"}, 32'($countones(g) <= 1), 32'd1);
    endtask

    task automatic cycle4(input string name, input logic p, input int ph, input int wy,
                          input logic epw);
        logic [3:0] oh, er, ea, eg;
        logic ew;
        oh = 4'b0001 << wy;
        er = 4'hF; ea = 4'h0; eg = 4'h0; ew = 1'b0;
        case (ph)
            1: ea = oh;
            2: begin er = ~oh; eg = oh; end
            3: begin er = ~oh; ea = oh; end
            4: ew = 1'b1;
            default: ;
        endcase
        ped_req4 = p;
        @(posedge clk);
        #1;
        chk(name, {18'd0, r4, a4, g4, walk4, ped_wait4}, {18'd0, er, ea, eg, ew, epw});
    endtask

    initial begin
        rst_n = 1'b0; flash = 1'b0; ped_req = 1'b0;
        rst_n4 = 1'b0; flash4 = 1'b0; ped_req4 = 1'b0;

        // basic rotation
        add_ra0(0, 0, 2, 0); add_g0(0, 4, 0); add_a0(3, 0); add_ar(0, 0, 1, 0);
        add_ra1(2, 0); add_g1(4, 0); add_a1(3, 0); add_ar(0, 0, 1, 0);
        add_ra0(0, 0, 2, 0);
        // single-cycle ped_req in GREEN(0), served after the rotation
        add_g0(1, 1, 1); add_g0(0, 3, 1); add_a0(3, 1); add_ar(0, 0, 1, 1);
        add_ra1(2, 1); add_g1(4, 1); add_a1(3, 1); add_ar(0, 0, 1, 1);
        add_walk(0, 5, 0); add_ar(0, 0, 1, 0); add_ra0(0, 0, 2, 0);
        // ped_req held across WALK entry keeps the request pending
        add_g0(0, 4, 0); add_a0(3, 0); add_ar(0, 0, 1, 0);
        add_ra1(2, 0); add_g1(4, 0); add_a1(3, 0); add_ar(0, 1, 1, 1);
        add_walk(1, 1, 1); add_walk(0, 4, 1); add_ar(0, 0, 1, 1); add_ra0(0, 0, 2, 1);
        add_g0(0, 4, 1); add_a0(3, 1); add_ar(0, 0, 1, 1);
        add_ra1(2, 1); add_g1(4, 1); add_a1(3, 1); add_ar(0, 0, 1, 1);
        add_walk(0, 5, 0); add_ar(0, 0, 1, 0); add_ra0(0, 0, 2, 0);
        // flash mid-GREEN(1); ped_req during flash is retained
        add_g0(0, 4, 0); add_a0(3, 0); add_ar(0, 0, 1, 0);
        add_ra1(2, 0); add_g1(2, 0);
        add(1, 0, 2, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        add(1, 1, 2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        add(1, 0, 2, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
        add(1, 0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        add_ar(0, 0, 1, 1); add_ra0(0, 0, 2, 1);

        #12;
        chk("reset_state", {24'd0, r, a, g, walk, ped_wait}, {24'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0});
        chk("reset_state4", {18'd0, r4, a4, g4, walk4, ped_wait4}, {18'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cycle2($sformatf("vec%0d_%0d", i, k), tbl[i].flash, tbl[i].ped,
                       tbl[i].r, tbl[i].a, tbl[i].g, tbl[i].walk, tbl[i].pw);
            end
        end

        // asynchronous reset mid-AMBER(0) with a request pending
        for (int k = 0; k < 4; k++) cycle2($sformatf("pre_rst_g0_%0d", k), 0, 0, 2'b10, 2'b00, 2'b01, 0, 1);
        cycle2("pre_rst_a0", 0, 0, 2'b10, 2'b01, 2'b00, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {24'd0, r, a, g, walk, ped_wait}, {24'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        cycle2("post_rst_ra0", 0, 0, 2'b11, 2'b01, 2'b00, 0, 0);
        cycle2("post_rst_ra0b", 0, 0, 2'b11, 2'b01, 2'b00, 0, 0);

        // 4-way, short timers: request latched on the first edge after reset
        @(negedge clk);
        rst_n4 = 1'b1;
        cycle4("w4_ra0_0", 1'b1, 1, 0, 1'b1);
        cycle4("w4_ra0_1", 1'b0, 1, 0, 1'b1);
        for (int wy = 0; wy < 4; wy++) begin
            if (wy != 0) begin
                cycle4($sformatf("w4_ra%0d_0", wy), 1'b0, 1, wy, 1'b1);
                cycle4($sformatf("w4_ra%0d_1", wy), 1'b0, 1, wy, 1'b1);
            end
            cycle4($sformatf("w4_g%0d", wy), 1'b0, 2, wy, 1'b1);
            for (int k = 0; k < 3; k++) cycle4($sformatf("w4_a%0d_%0d", wy, k), 1'b0, 3, wy, 1'b1);
            cycle4($sformatf("w4_ar%0d", wy), 1'b0, 0, 0, 1'b1);
        end
        for (int k = 0; k < 3; k++) cycle4($sformatf("w4_walk_%0d", k), 1'b0, 4, 0, 1'b0);
        cycle4("w4_ar_post", 1'b0, 0, 0, 1'b0);
        cycle4("w4_ra0_post0", 1'b0, 1, 0, 1'b0);
        cycle4("w4_ra0_post1", 1'b0, 1, 0, 1'b0);
        cycle4("w4_g0_post", 1'b0, 2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
